// File: rtl/mem_resp_pkg.sv
// mem_resp_pkg: shared state encoding and counter sizing for the memory responder
package mem_resp_pkg;
    typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT} state_t;
    function automatic int cnt_width(input int n);
        return $clog2(n + 2);
    endfunction
endpackage

// File: rtl/mem_wait_responder_if.sv
// mem_wait_responder_if: cache-to-memory request/response bundle
interface mem_wait_responder_if #(
    parameter int ADDRBITS = 32,
    parameter int DATABITS = 32
);
    logic [ADDRBITS-1:0] mem_addr;
    logic [DATABITS-1:0] mem_in;
    logic                mem_wrreq;
    logic                mem_rdreq;
    logic [DATABITS-1:0] mem_out;
    logic                mem_out_valid;
    logic                mem_err;
    modport master (
        output mem_addr, mem_in, mem_wrreq, mem_rdreq,
        input  mem_out, mem_out_valid, mem_err
    );
    modport slave (
        input  mem_addr, mem_in, mem_wrreq, mem_rdreq,
        output mem_out, mem_out_valid, mem_err
    );
endinterface

// File: rtl/mem_resp_ram.sv
// mem_resp_ram: single-port synchronous RAM, write has priority, read output held between reads
module mem_resp_ram #(
    parameter int DATABITS    = 32,
    parameter int MEMADDRBITS = 10
) (
    input  logic                   clk,
    input  logic                   we,
    input  logic                   re,
    input  logic [MEMADDRBITS-1:0] addr,
    input  logic [DATABITS-1:0]    wdata,
    output logic [DATABITS-1:0]    rdata
);
    logic [DATABITS-1:0] mem [2**MEMADDRBITS];

    always_ff @(posedge clk) begin
        if (we)
            mem[addr] <= wdata;
        else if (re)
            rdata <= mem[addr];
    end
endmodule

// File: rtl/mem_wait_responder.sv
// mem_wait_responder: word-addressed RAM target with configurable wait states and sticky overlap error
module mem_wait_responder
    import mem_resp_pkg::*;
#(
    parameter int ADDRBITS    = 32,
    parameter int DATABITS    = 32,
    parameter int MEMADDRBITS = 10,
    parameter int WAIT_STATES = 2
) (
    input logic clk,
    input logic reset,
    mem_wait_responder_if.slave bus
);
    localparam int CW = cnt_width(WAIT_STATES);
    localparam logic [CW-1:0] WR_LOAD = CW'(WAIT_STATES);
    localparam logic [CW-1:0] RD_LOAD = CW'(WAIT_STATES > 0 ? WAIT_STATES - 1 : 0);

    state_t              state;
    logic [CW-1:0]       cnt;
    logic                rd_pend;
    logic                valid;
    logic                err;
    logic [DATABITS-1:0] out;
    logic [DATABITS-1:0] rdata;
    logic                req;
    logic                we;
    logic                re;
    logic                unused_addr;

    assign req         = bus.mem_rdreq | bus.mem_wrreq;
    assign we          = !reset && state == IDLE && bus.mem_wrreq;
    assign re          = !reset && state == IDLE && bus.mem_rdreq && !bus.mem_wrreq;
    assign unused_addr = ^{bus.mem_addr[ADDRBITS-1:MEMADDRBITS+2], bus.mem_addr[1:0]};

    assign bus.mem_out       = out;
    assign bus.mem_out_valid = valid;
    assign bus.mem_err       = err;

    mem_resp_ram #(.DATABITS(DATABITS), .MEMADDRBITS(MEMADDRBITS)) u_ram (
        .clk  (clk),
        .we   (we),
        .re   (re),
        .addr (bus.mem_addr[MEMADDRBITS+1:2]),
        .wdata(bus.mem_in),
        .rdata(rdata)
    );

    // With zero wait states reads pipeline: rd_pend copies the RAM output one edge later.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            rd_pend <= 1'b0;
            valid   <= 1'b1;
            out     <= '0;
            err     <= 1'b0;
        end else begin
            rd_pend <= 1'b0;
            if (rd_pend)
                out <= rdata;
            case (state)
                IDLE: begin
                    if (we) begin
                        state <= WR_WAIT;
                        cnt   <= WR_LOAD;
                        valid <= 1'b0;
                    end else if (re) begin
                        if (WAIT_STATES == 0) begin
                            rd_pend <= 1'b1;
                        end else begin
                            state <= RD_WAIT;
                            cnt   <= RD_LOAD;
                            valid <= 1'b0;
                        end
                    end
                end
                RD_WAIT: begin
                    if (cnt == '0) begin
                        state <= IDLE;
                        valid <= 1'b1;
                        out   <= rdata;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                WR_WAIT: begin
                    if (cnt == '0) begin
                        state <= IDLE;
                        valid <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
            if (state != IDLE && req)
                err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_mem_wait_responder.sv
// tb_mem_wait_responder: directed vector table for N=2 plus hand-written N=0 pipelined-read sequence
module tb_mem_wait_responder;
    logic clk;
    logic reset;
    int tests;
    int fails;

    mem_wait_responder_if #(.ADDRBITS(32), .DATABITS(32)) b2();
    mem_wait_responder_if #(.ADDRBITS(32), .DATABITS(32)) b0();

    mem_wait_responder #(.ADDRBITS(32), .DATABITS(32), .MEMADDRBITS(10), .WAIT_STATES(2)) dut2 (
        .clk(clk), .reset(reset), .bus(b2)
    );
    mem_wait_responder #(.ADDRBITS(32), .DATABITS(32), .MEMADDRBITS(10), .WAIT_STATES(0)) dut0 (
        .clk(clk), .reset(reset), .bus(b0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] din;
        logic        ev;
        logic [31:0] eo;
        logic        ee;
    } vec_t;

    vec_t vecs[$];

    task automatic row(input logic rst, input logic rd, input logic wr, input logic [31:0] addr,
                       input logic [31:0] din, input logic ev, input logic [31:0] eo, input logic ee);
        vec_t v;
        v.rst = rst; v.rd = rd; v.wr = wr; v.addr = addr; v.din = din;
        v.ev = ev; v.eo = eo; v.ee = ee;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step0(input logic rd, input logic wr, input logic [31:0] addr, input logic [31:0] din);
        @(negedge clk);
        b0.mem_rdreq = rd;
        b0.mem_wrreq = wr;
        b0.mem_addr  = addr;
        b0.mem_in    = din;
        @(posedge clk);
        #1;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b1;
        {b2.mem_rdreq, b2.mem_wrreq, b2.mem_addr, b2.mem_in} = '0;
        {b0.mem_rdreq, b0.mem_wrreq, b0.mem_addr, b0.mem_in} = '0;

        // rst rd wr addr din | valid out err (after the edge)
        row(1, 0, 0, 32'h0,        32'h0,        1, 32'h0,        0);
        row(0, 0, 0, 32'h0,        32'h0,        1, 32'h0,        0);
        row(0, 0, 1, 32'h80000000, 32'h0FFF0001, 0, 32'h0,        0);
        row(0, 0, 0, 32'h0,        32'h0,        0, 32'h0,        0);
        row(0, 0, 0, 32'h0,        32'h0,        0, 32'h0,        0);
        row(0, 0, 0, 32'h0,        32'h0,        1, 32'h0,        0);
        row(0, 1, 0, 32'h80000000, 32'h0,        0, 32'h0,        0);
        row(0, 0, 0, 32'h0,        32'h0,        0, 32'h0,        0);
        row(0, 0, 0, 32'h0,        32'h0,        1, 32'h0FFF0001, 0);
        row(0, 1, 1, 32'h100,      32'h100,      0, 32'h0FFF0001, 0);
        row(0, 0, 0, 32'h0,        32'h0,        0, 32'h0FFF0001, 0);
        row(0, 0, 0, 32'h0,        32'h0,        0, 32'h0FFF0001, 0);
        row(0, 0, 0, 32'h0,        32'h0,        1, 32'h0FFF0001, 0);
        row(0, 1, 0, 32'h100,      32'h0,        0, 32'h0FFF0001, 0);
        row(0, 1, 0, 32'h100,      32'h0,        0, 32'h0FFF0001, 1);
        row(0, 0, 0, 32'h0,        32'h0,        1, 32'h100,      1);
        row(1, 0, 0, 32'h0,        32'h0,        1, 32'h0,        0);
        row(0, 0, 1, 32'h1000,     32'hDEADBEEF, 0, 32'h0,        0);
        row(0, 0, 0, 32'h0,        32'h0,        0, 32'h0,        0);
        row(0, 0, 0, 32'h0,        32'h0,        0, 32'h0,        0);
        row(0, 0, 0, 32'h0,        32'h0,        1, 32'h0,        0);
        row(0, 1, 0, 32'h0,        32'h0,        0, 32'h0,        0);
        row(0, 0, 0, 32'h0,        32'h0,        0, 32'h0,        0);
        row(0, 0, 0, 32'h0,        32'h0,        1, 32'hDEADBEEF, 0);
        row(0, 1, 0, 32'h0,        32'h0,        0, 32'hDEADBEEF, 0);
        row(1, 0, 0, 32'h0,        32'h0,        1, 32'h0,        0);
        row(0, 0, 0, 32'h0,        32'h0,        1, 32'h0,        0);
        row(0, 0, 0, 32'h0,        32'h0,        1, 32'h0,        0);
        row(0, 1, 0, 32'h0,        32'h0,        0, 32'h0,        0);
        row(0, 0, 0, 32'h0,        32'h0,        0, 32'h0,        0);
        row(0, 0, 0, 32'h0,        32'h0,        1, 32'hDEADBEEF, 0);
        row(0, 0, 1, 32'h8,        32'h5,        0, 32'hDEADBEEF, 0);
        row(0, 0, 1, 32'hC,        32'h9,        0, 32'hDEADBEEF, 1);
        row(0, 0, 0, 32'h0,        32'h0,        0, 32'hDEADBEEF, 1);
        row(0, 0, 0, 32'h0,        32'h0,        1, 32'hDEADBEEF, 1);
        row(0, 1, 0, 32'h8,        32'h0,        0, 32'hDEADBEEF, 1);
        row(0, 0, 0, 32'h0,        32'h0,        0, 32'hDEADBEEF, 1);
        row(0, 0, 0, 32'h0,        32'h0,        1, 32'h5,        1);
        row(1, 0, 1, 32'h8,        32'h7,        1, 32'h0,        0);
        row(0, 1, 0, 32'h8,        32'h0,        0, 32'h0,        0);
        row(0, 0, 0, 32'h0,        32'h0,        0, 32'h0,        0);
        row(0, 0, 0, 32'h0,        32'h0,        1, 32'h5,        0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            reset        = vecs[i].rst;
            b2.mem_rdreq = vecs[i].rd;
            b2.mem_wrreq = vecs[i].wr;
            b2.mem_addr  = vecs[i].addr;
            b2.mem_in    = vecs[i].din;
            @(posedge clk);
            #1;
            check($sformatf("v%0d_valid", i), {31'b0, b2.mem_out_valid}, {31'b0, vecs[i].ev});
            check($sformatf("v%0d_out", i), b2.mem_out, vecs[i].eo);
            check($sformatf("v%0d_err", i), {31'b0, b2.mem_err}, {31'b0, vecs[i].ee});
        end
        @(negedge clk);
        reset = 1'b0;
        {b2.mem_rdreq, b2.mem_wrreq} = '0;

        // N=0: each write is a single busy cycle
        for (int i = 0; i < 4; i++) begin
            step0(1'b0, 1'b1, 32'(i * 4), 32'h0FFF0001 + 32'(i));
            check($sformatf("n0_wr%0d_busy", i), {31'b0, b0.mem_out_valid}, 32'd0);
            step0(1'b0, 1'b0, 32'h0, 32'h0);
            check($sformatf("n0_wr%0d_idle", i), {31'b0, b0.mem_out_valid}, 32'd1);
        end
        // N=0: back-to-back reads, data lands one edge after each acceptance
        for (int i = 0; i < 5; i++) begin
            step0(i < 4, 1'b0, 32'(i * 4), 32'h0);
            check($sformatf("n0_rd%0d_valid", i), {31'b0, b0.mem_out_valid}, 32'd1);
            check($sformatf("n0_rd%0d_out", i), b0.mem_out, i == 0 ? 32'h0 : 32'h0FFF0000 + 32'(i));
        end
        check("n0_err", {31'b0, b0.mem_err}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
